// File: rtl/pht_access_scheduler.sv
// Single-port PHT access sequencer: initialises the table, arbitrates predict lookups against
// queued counter updates, performs each update's read-modify-write and owns the GHR.
module pht_access_scheduler #(
  parameter int unsigned R = 4,
  parameter int unsigned M = 2,
  parameter int unsigned N = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pred_req,
  input  logic [31:0]    pred_pc,
  output logic           pred_ready,
  output logic           pred_valid,
  output logic           pred_taken,
  output logic [M-1:0]   pred_hist,
  input  logic           upd_valid,
  input  logic [31:0]    upd_pc,
  input  logic [M-1:0]   upd_hist,
  input  logic           upd_taken,
  output logic           upd_ready,
  output logic           init_done,
  output logic [R+M-1:0] ram_addr,
  output logic [N-1:0]   ram_wdata,
  input  logic [N-1:0]   ram_rdata,
  output logic           ram_cs_n,
  output logic           ram_we_n,
  output logic           ram_oe_n
);

  localparam int unsigned AW = R + M;
  localparam int unsigned EW = R + M + 1;
  localparam logic [N-1:0] InitVal = {1'b0, {(N - 1){1'b1}}};

  typedef enum logic [2:0] {StInit, StIdle, StPRd, StPRsp, StURd, StUCalc, StUWr} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   init_cnt_q;
  logic            armed_q;
  logic            init_done_q;
  logic [M-1:0]    ghr_q;
  logic [AW-1:0]   pred_addr_q;
  logic [M-1:0]    pred_hist_q;
  logic [EW-1:0]   fifo_q [2];
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      count_q;
  logic [N-1:0]    new_cnt_q, new_cnt;

  logic            accept, pop, push, full;
  logic [EW-1:0]   head;
  logic [AW-1:0]   head_addr;
  logic            head_taken;
  logic            unused_pc;

  assign unused_pc  = ^{pred_pc[31:R], upd_pc[31:R]};
  assign full       = (count_q == 2'd2);
  assign upd_ready  = ~full;
  assign push       = upd_valid & upd_ready;
  assign head       = fifo_q[rd_ptr_q];
  assign head_addr  = head[EW-1:1];
  assign head_taken = head[0];
  assign pred_hist  = pred_hist_q;
  assign init_done  = init_done_q;

  always_comb begin
    if (head_taken) begin
      new_cnt = (ram_rdata == '1) ? ram_rdata : ram_rdata + 1'b1;
    end else begin
      new_cnt = (ram_rdata == '0) ? ram_rdata : ram_rdata - 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pred_ready = 1'b0;
    pred_valid = 1'b0;
    pred_taken = 1'b0;
    ram_cs_n   = 1'b1;
    ram_we_n   = 1'b1;
    ram_oe_n   = 1'b1;
    ram_addr   = '0;
    ram_wdata  = '0;
    accept     = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      StInit: begin
        // armed_q keeps the strobes quiet while reset is still held
        if (armed_q) begin
          ram_cs_n  = 1'b0;
          ram_we_n  = 1'b0;
          ram_addr  = init_cnt_q;
          ram_wdata = InitVal;
          if (init_cnt_q == '1) state_d = StIdle;
        end
      end
      StIdle: begin
        if (full) begin
          state_d = StURd;
        end else begin
          pred_ready = 1'b1;
          if (pred_req) begin
            accept  = 1'b1;
            state_d = StPRd;
          end else if (count_q != 2'd0) begin
            state_d = StURd;
          end
        end
      end
      StPRd: begin
        ram_cs_n = 1'b0;
        ram_oe_n = 1'b0;
        ram_addr = pred_addr_q;
        state_d  = StPRsp;
      end
      StPRsp: begin
        pred_valid = 1'b1;
        pred_taken = ram_rdata[N-1];
        state_d    = StIdle;
      end
      StURd: begin
        ram_cs_n = 1'b0;
        ram_oe_n = 1'b0;
        ram_addr = head_addr;
        state_d  = StUCalc;
      end
      StUCalc: begin
        ram_addr = head_addr;
        state_d  = StUWr;
      end
      StUWr: begin
        ram_cs_n  = 1'b0;
        ram_we_n  = 1'b0;
        ram_addr  = head_addr;
        ram_wdata = new_cnt_q;
        pop       = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      armed_q     <= 1'b0;
      init_done_q <= 1'b0;
      ghr_q       <= '0;
      pred_addr_q <= '0;
      pred_hist_q <= '0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      new_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      if (state_q == StInit && armed_q) begin
        init_cnt_q <= init_cnt_q + 1'b1;
        if (init_cnt_q == '1) init_done_q <= 1'b1;
      end
      if (accept) begin
        pred_addr_q <= {pred_pc[R-1:0], ghr_q};
        pred_hist_q <= ghr_q;
      end
      if (state_q == StUCalc) new_cnt_q <= new_cnt;
      if (pop) begin
        ghr_q    <= {ghr_q[M-2:0], head_taken};
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= {upd_pc[R-1:0], upd_hist, upd_taken};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
